// File: rtl/gpr_file_pkg.sv
// ============================================================================
// Module   : gpr_file_pkg
// Brief    : Shared CPU constants for the register file and destination select.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gpr_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  // Link register, targeted by the destination-select mux for jal/bgezal.
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

`default_nettype wire

// File: rtl/gpr_file_wr_decode.sv
// ============================================================================
// Module   : gpr_file_wr_decode
// Brief    : Enabled address-to-one-hot decoder; output bit 0 is always 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpr_file_wr_decode #(
  parameter int ADDR_W = gpr_file_pkg::ADDR_W,
  parameter int NREGS  = 1 << ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREGS-1:0]  onehot
);

  // $zero can never be selected, so its line is tied off rather than decoded.
  assign onehot[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_dec
    assign onehot[i] = en & (addr == ADDR_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/gpr_file.sv
// ============================================================================
// Module   : gpr_file
// Brief    : 32x32 GPR file, 2 bypassed read ports, 1 write port, busy scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpr_file
  import gpr_file_pkg::REG_ZERO;
#(
  parameter int DATA_W = gpr_file_pkg::DATA_W,
  parameter int ADDR_W = gpr_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic [ADDR_W:0]   r_pend;

  logic [NREGS-1:0]  w_wr_vec;
  logic [NREGS-1:0]  w_set_vec;
  logic [NREGS-1:0]  w_busy_next;
  logic [ADDR_W:0]   w_pop;
  logic              w_rs_hit;
  logic              w_rt_hit;

  gpr_file_wr_decode #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_wr_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (w_wr_vec)
  );

  gpr_file_wr_decode #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_set_dec (
    .en     (iss_en),
    .addr   (iss_addr),
    .onehot (w_set_vec)
  );

  // The write-enable vector doubles as the clear vector; set is applied last
  // so a new producer wins over one retiring to the same register.
  assign w_busy_next = (r_busy & ~w_wr_vec) | w_set_vec;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_pop = w_pop + (ADDR_W+1)'(w_busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_vec[i]) begin
          r_regs[i] <= wr_data;
        end
      end
      r_busy <= w_busy_next;
      r_pend <= w_pop;
    end
  end

  assign w_rs_hit = wr_en & (wr_addr == rs_addr);
  assign w_rt_hit = wr_en & (wr_addr == rt_addr);

  // Bypass is gated by rst_n so reads stay zero while reset is held.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != REG_ZERO) begin
      rs_data = (w_rs_hit & rst_n) ? wr_data : r_regs[rs_addr];
    end
    if (rt_addr != REG_ZERO) begin
      rt_data = (w_rt_hit & rst_n) ? wr_data : r_regs[rt_addr];
    end
  end

  assign rs_busy  = r_busy[rs_addr] & ~w_rs_hit;
  assign rt_busy  = r_busy[rt_addr] & ~w_rt_hit;
  assign pend_cnt = r_pend;

endmodule

`default_nettype wire
